// File: rtl/uart_fifo_tx_if.sv
// FIFO read-side handshake between the UART transmitter (master, the reader)
// and the TX FIFO (slave).
interface uart_fifo_tx_if #(
   parameter int DBIT = 8
);
   logic            fifo_empty;
   logic [DBIT-1:0] fifo_data;
   logic            fifo_rd_en;

   modport master (input fifo_empty, fifo_data, output fifo_rd_en);
   modport slave  (output fifo_empty, fifo_data, input fifo_rd_en);
endinterface

// File: rtl/uart_fifo_tx.sv
// UART transmitter: pops bytes from the TX FIFO and serialises them as
// start / DBIT data (LSB first) / stop, timed by the shared oversampling tick.
module uart_fifo_tx #(
   parameter int DBIT       = 8,
   parameter int OVERSAMPLE = 16,
   parameter int SB_TICK    = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 s_tick,
   input  logic                 tx_en,
   uart_fifo_tx_if.master       fifo,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done_tick
);
   localparam int TMAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
   localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
   localparam int BW   = (DBIT > 2) ? $clog2(DBIT) : 1;
   localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_e;

   state_e          state_q, state_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic [BW-1:0]   bit_q, bit_d;
   logic [DBIT-1:0] shift_q, shift_d;
   logic            tx_q, tx_d;
   logic            done_q, done_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE:  if (tx_en && !fifo.fifo_empty) state_d = FETCH;
         FETCH: state_d = LOAD;
         LOAD: begin
            shift_d = fifo.fifo_data;
            tick_d  = '0;
            state_d = START;
         end
         START: if (s_tick) begin
            if (tick_q == OS_LAST) begin
               tick_d  = '0;
               bit_d   = '0;
               state_d = DATA;
            end else tick_d = tick_q + 1'b1;
         end
         DATA: if (s_tick) begin
            if (tick_q == OS_LAST) begin
               tick_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == BIT_LAST) state_d = STOP;
               else                   bit_d   = bit_q + 1'b1;
            end else tick_d = tick_q + 1'b1;
         end
         STOP: if (s_tick) begin
            if (tick_q == SB_LAST) begin
               tick_d  = '0;
               done_d  = 1'b1;
               state_d = IDLE;
            end else tick_d = tick_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // Line level follows the next state so tx switches on the same edge.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   assign fifo.fifo_rd_en = (state_q == FETCH);
   assign tx              = tx_q;
   assign tx_busy         = (state_q != IDLE);
   assign tx_done_tick    = done_q;
endmodule

// File: tb/tb_uart_fifo_tx.sv
// Randomised bench for uart_fifo_tx: FIFO model, tick-counting line decoder
// and byte scoreboard; runs a 1-stop-bit and a 2-stop-bit instance.
module tb_uart_fifo_tx;
   logic clk = 1'b0;
   logic reset_n, s_tick, tx_en, sel;
   logic tx16, busy16, done16, tx32, busy32, done32;
   logic fifo_empty_v;
   logic [7:0] fdata;
   logic [7:0] q[$];
   logic [7:0] exp_q[$];
   int checks = 0, errors = 0, pops = 0, frames = 0;
   int per = 10, ph = 0;
   int mon_n = 0;
   logic in_frame = 1'b0;

   uart_fifo_tx_if #(.DBIT(8)) if16 ();
   uart_fifo_tx_if #(.DBIT(8)) if32 ();

   assign if16.fifo_empty = sel ? 1'b1 : fifo_empty_v;
   assign if32.fifo_empty = sel ? fifo_empty_v : 1'b1;
   assign if16.fifo_data  = fdata;
   assign if32.fifo_data  = fdata;

   uart_fifo_tx #(.DBIT(8), .OVERSAMPLE(16), .SB_TICK(16)) dut (
      .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_en(tx_en), .fifo(if16),
      .tx(tx16), .tx_busy(busy16), .tx_done_tick(done16));

   uart_fifo_tx #(.DBIT(8), .OVERSAMPLE(16), .SB_TICK(32)) dut32 (
      .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_en(tx_en), .fifo(if32),
      .tx(tx32), .tx_busy(busy32), .tx_done_tick(done32));

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Baud tick: one pulse every 'per' clocks; per==1 holds it high.
   initial begin
      s_tick = 1'b0;
      forever begin
         @(negedge clk);
         ph++;
         s_tick = ((ph % per) == 0);
      end
   end

   // FIFO model: registered read data, pop on rd_en.
   initial begin
      logic rd, other, rd_prev;
      rd_prev = 1'b0;
      forever begin
         @(negedge clk);
         rd    = sel ? if32.fifo_rd_en : if16.fifo_rd_en;
         other = sel ? if16.fifo_rd_en : if32.fifo_rd_en;
         if (other) chk("rd_inactive", 1, 0);
         if (rd) begin
            if (rd_prev) chk("rd_width", 1, 0);
            chk("rd_nonempty", q.size() != 0, 1);
            if (q.size() != 0) begin
               fdata = q.pop_front();
               exp_q.push_back(fdata);
               pops++;
            end
         end
         rd_prev      = rd;
         fifo_empty_v = (q.size() == 0);
      end
   end

   // Line decoder: a bit is 16 ticks, sampled at its centre tick.
   initial begin
      logic mt, md, tx_prev, gap_chk;
      logic [7:0] acc;
      int cyc, stop_t, done_cyc, sbt, bi;
      tx_prev = 1'b1; gap_chk = 1'b0; cyc = 0; stop_t = 0; done_cyc = 0; acc = '0;
      forever begin
         @(posedge clk); #1;
         cyc++;
         mt  = sel ? tx32 : tx16;
         md  = sel ? done32 : done16;
         sbt = sel ? 32 : 16;
         if (!reset_n) begin
            in_frame = 1'b0; gap_chk = 1'b0; mt = 1'b1;
         end else if (!in_frame) begin
            if (md) chk("done_spurious", 1, 0);
            if (tx_prev && !mt) begin
               in_frame = 1'b1; mon_n = 0; acc = '0;
               if (gap_chk) chk("gap", cyc - done_cyc, 3);
               gap_chk = 1'b0;
            end
         end else begin
            if (s_tick) begin
               mon_n++;
               if (mon_n % 16 == 8) begin
                  bi = mon_n / 16;
                  if (bi == 0)      chk("start_bit", mt, 0);
                  else if (bi <= 8) acc[bi-1] = mt;
                  else              chk("stop_bit", mt, 1);
               end
               if (mon_n == 144) stop_t = cyc;
            end
            if (md) begin
               chk("done_pos", mon_n, 144 + sbt);
               chk("stop_clk", cyc - stop_t, sbt * per);
               if (exp_q.size() == 0) chk("exp_empty", 1, 0);
               else                   chk("byte", acc, exp_q.pop_front());
               frames++;
               in_frame = 1'b0;
               done_cyc = cyc;
               gap_chk  = !fifo_empty_v && tx_en;
            end else if (mon_n > 144 + sbt) begin
               chk("done_missing", 0, 1);
               in_frame = 1'b0;
            end
         end
         tx_prev = mt;
      end
   end

   task automatic push(input logic [7:0] b);
      q.push_back(b);
      fifo_empty_v = 1'b0;
   endtask

   task automatic wait_frames(input int target, input int budget);
      int c = 0;
      while (frames < target && c < budget) begin @(negedge clk); c++; end
      chk("frame_wait", frames, target);
   endtask

   task automatic wait_n(input int target, input int budget);
      int c = 0;
      while (!(in_frame && mon_n >= target) && c < budget) begin @(negedge clk); c++; end
      chk("wait_bit", in_frame && mon_n >= target, 1);
   endtask

   initial begin
      reset_n = 1'b0; tx_en = 1'b1; sel = 1'b0; fifo_empty_v = 1'b1; fdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_tx", tx16, 1);
      chk("rst_busy", busy16, 0);
      chk("rst_done", done16, 0);
      chk("rst_rd", if16.fifo_rd_en, 0);
      chk("rst_tx32", tx32, 1);
      reset_n = 1'b1;

      // Empty FIFO: line stays idle
      for (int i = 0; i < 10; i++) begin
         repeat (100) @(negedge clk);
         chk("idle_tx", tx16, 1);
         chk("idle_busy", busy16, 0);
      end
      chk("idle_pops", pops, 0);

      push(8'h55);
      wait_frames(1, 3000);
      chk("p55_pops", pops, 1);

      push(8'hA3); push(8'h00); push(8'hFF);
      wait_frames(4, 8000);
      chk("b2b_pops", pops, 4);
      repeat (5) @(negedge clk);
      chk("b2b_idle", busy16, 0);

      // tx_en dropped during data bit 3
      push(8'h3C); push(8'h11);
      wait_n(70, 3000);
      tx_en = 1'b0;
      wait_frames(5, 3000);
      repeat (2000) @(negedge clk);
      chk("en_off_pops", pops, 5);
      chk("en_off_busy", busy16, 0);
      tx_en = 1'b1;
      wait_frames(6, 3000);
      chk("en_on_pops", pops, 6);

      // Reset mid-frame discards the byte in flight
      push(8'hF0); push(8'h5A);
      wait_n(56, 3000);
      #2 reset_n = 1'b0;
      #1 chk("mid_rst_tx", tx16, 1);
      chk("mid_rst_busy", busy16, 0);
      exp_q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      wait_frames(7, 3000);
      chk("rst_pops", pops, 8);

      // s_tick held high, random bytes
      per = 1;
      for (int i = 0; i < 6; i++) push(8'($urandom_range(0, 255)));
      wait_frames(13, 3000);
      repeat (5) @(negedge clk);
      per = 7;
      repeat (10) @(negedge clk);
      for (int i = 0; i < 4; i++) push(8'($urandom_range(0, 255)));
      wait_frames(17, 6000);
      chk("rand_pops", pops, 18);

      // Two stop bits on the second instance
      repeat (5) @(negedge clk);
      per = 10;
      sel = 1'b1;
      repeat (20) @(negedge clk);
      push(8'h81);
      push(8'($urandom_range(0, 255)));
      wait_frames(19, 5000);
      chk("sb32_pops", pops, 20);
      repeat (5) @(negedge clk);
      chk("sb32_idle", busy32, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_fifo_tx.md
Name: uart_fifo_tx

Overview:
UART transmitter that drains the TX-side FIFO and serialises each byte onto the line. It is the reader of the FIFO: it pops one word via the FIFO read handshake and sends it as start bit, DBIT data bits LSB-first, then stop bit(s). Bit timing comes from the shared oversampling baud tick, the same tick the receiver uses.

Parameters:
DBIT, 8, data bits per frame; equals the FIFO word width.
OVERSAMPLE, 16, s_tick pulses per bit period.
SB_TICK, 16, s_tick pulses in the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
s_tick  input  1  baud oversampling strobe, one clk wide.
tx_en  input  1  when 0, no new frame is fetched; a frame already in flight completes.
fifo_empty  input  1  FIFO empty flag.
fifo_data  input  DBIT  FIFO registered read data, valid the cycle after fifo_rd_en.
fifo_rd_en  output  1  one-cycle pop request to the FIFO.
tx  output  1  serial line, idle high, registered.
tx_busy  output  1  high whenever state is not IDLE.
tx_done_tick  output  1  one-clk pulse at the end of each frame's stop period.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (reset_n).
- Reset values: state=IDLE, tx=1, fifo_rd_en=0, tx_busy=0, tx_done_tick=0, tick_cnt=0, bit_cnt=0, shift register=0.
- State machine: IDLE, FETCH, LOAD, START, DATA, STOP.
- IDLE: tx=1. If tx_en=1 and fifo_empty=0, go to FETCH. Otherwise stay.
- FETCH: fifo_rd_en=1 for exactly this one cycle. Go to LOAD unconditionally.
- LOAD: fifo_data is valid in this cycle. Capture it into the shift register at the exiting edge. Clear tick_cnt. Go to START.
- START: tx=0. On each s_tick, increment tick_cnt. On s_tick with tick_cnt==OVERSAMPLE-1: clear tick_cnt and bit_cnt, go to DATA.
- DATA: tx=shift[0]. On s_tick with tick_cnt==OVERSAMPLE-1: clear tick_cnt and shift right by one.
  - If bit_cnt==DBIT-1, go to STOP.
  - Otherwise increment bit_cnt.
- STOP: tx=1. On s_tick with tick_cnt==SB_TICK-1: pulse tx_done_tick for one clk and return to IDLE.
- Ticks: tick_cnt advances only on s_tick. Clocks without s_tick hold all counters.
- Counter widths: tick_cnt is wide enough for max(OVERSAMPLE, SB_TICK)-1. bit_cnt is clog2(DBIT) bits.
- tx is driven from a register. No combinational glitches reach the line.
- Back-to-back frames: if the FIFO is still non-empty at IDLE after tx_done_tick, FETCH starts on the next clk. The inter-frame gap is IDLE+FETCH+LOAD (3 clk) plus alignment to the next s_tick. There are no extra stop bits.
- Empty boundary: fifo_rd_en is never asserted while fifo_empty=1 in IDLE. The empty flag is sampled only in IDLE.
- tx_en deassertion mid-frame: the current frame completes. The block then parks in IDLE.
- Reset mid-frame: tx returns to 1 asynchronously and the byte in flight is discarded. The FIFO is not re-read.
- s_tick held high continuously: legal. Each clk counts as one tick.

Test Plan:
1. Reset, FIFO empty, tx_en=1, s_tick every 10 clk -> tx=1, fifo_rd_en never asserted, tx_busy=0 for 1000 clk.
2. FIFO supplies 0x55 -> fifo_rd_en pulses once, for 1 clk. Line shows start bit 0, then bits 1,0,1,0,1,0,1,0, then stop bit 1, each bit 160 clk. tx_done_tick pulses once at the end of the stop period.
3. Three bytes 0xA3, 0x00, 0xFF queued -> exactly 3 fifo_rd_en pulses and 3 back-to-back frames decoded correctly. Gap between frames ≤ 3 clk + 1 tick period. Block returns to IDLE when fifo_empty=1.
4. tx_en dropped during DATA bit 3 of 0x3C -> frame completes with correct bits. No further fifo_rd_en while tx_en=0 even with the FIFO non-empty. Transmission resumes after tx_en=1.
5. reset_n asserted mid-DATA of 0xF0 -> tx=1 immediately and state=IDLE. After release, the next FIFO byte is sent cleanly.
6. SB_TICK=32, byte 0x81 -> stop period is 320 clk. tx_done_tick is a single 1-clk pulse.
